// File: rtl/hazard_controller.sv
// Hazard and stall controller for a 5-stage RV32I pipeline (F/D/E/M/W).
// Produces per-stage stall/flush controls and E-stage forwarding selects,
// sequences multi-cycle data-memory accesses through a wait FSM with a
// timeout watchdog, and keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, rst                 clock (rising edge) and async active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E     source registers of the instructions in D and E
//   RdE/RdM/RdW              destination registers in E, M and W
//   ResultSrcE0              instruction in E is a load
//   RegWriteM/RegWriteW      M/W stage writes the register file
//   PCSrcE                   redirect resolved in E
//   MemReqM/MemReadyM        data-memory request / completion for M
//   CntClr                   synchronous clear of the perf counters
//   StallF/D/E/M             hold the pipeline register feeding that stage
//   FlushD/E/W               inject a bubble into that stage
//   ForwardAE/BE             00 regfile, 01 W result, 10 M ALU result
//   MemErr                   registered, high while the FSM sits in ERR
//   StallCnt/FlushCnt        saturating performance counters
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_err_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               lw_stall, mem_stall;

  // M result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  always_comb begin
    lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mem_stall = ((state_q == StIdle) && MemReqM && !MemReadyM) ||
                ((state_q == StWait) && !MemReadyM) ||
                (state_q == StErr);
  end

  // Pipeline controls: a memory stall freezes everything and holds off any
  // redirect until the access completes; a redirect beats a load-use stall.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (MemReqM && !MemReadyM) begin
          state_d    = StWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StWait: begin
        if (MemReadyM) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if ((MEM_TIMEOUT != 0) && (32'(wait_cnt_q) + 32'd1 == MEM_TIMEOUT)) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((mem_stall || lw_stall) && (stall_cnt_q != CntMax)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (PCSrcE && !mem_stall && (flush_cnt_q != CntMax)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= (state_d == StErr);
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr   = mem_err_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CntClr;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] StallCnt, FlushCnt;
  logic [6:0] ctrl;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_controller #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .ResultSrcE0(ResultSrcE0),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .CntClr     (CntClr),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .MemErr     (MemErr),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctrl bit order: StallF StallD StallE StallM FlushD FlushE FlushW
  localparam logic [6:0] CtrlNone = 7'b0000000;
  localparam logic [6:0] CtrlLw   = 7'b1100010;
  localparam logic [6:0] CtrlRedir = 7'b0000110;
  localparam logic [6:0] CtrlMem  = 7'b1111001;

  initial begin
    rst = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CntClr} = '0;
    #3;
    check_eq("rst_memerr", 32'(MemErr), 32'd0);
    check_eq("rst_stallcnt", 32'(StallCnt), 32'd0);
    check_eq("rst_flushcnt", 32'(FlushCnt), 32'd0);
    check_eq("rst_ctrl", 32'(ctrl), 32'(CtrlNone));
    #9 rst = 1'b1;
    step();

    // Forwarding: M hit on A, W hit on B.
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    RegWriteW = 1'b1; RdW = 5'd6; Rs2E = 5'd6;
    #2 check_eq("fwd_m_w", 32'({ForwardAE, ForwardBE}), 32'b1001);
    // Both stages hit the same register: M wins.
    RdW = 5'd5; Rs2E = 5'd5;
    #2 check_eq("fwd_prio", 32'({ForwardAE, ForwardBE}), 32'b1010);
    // M not writing: fall back to W.
    RegWriteM = 1'b0;
    #2 check_eq("fwd_w_only", 32'({ForwardAE, ForwardBE}), 32'b0101);
    // x0 never forwards.
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    #2 check_eq("fwd_x0", 32'({ForwardAE, ForwardBE}), 32'b0000);
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    step();

    // Load-use on rs2.
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #2 check_eq("lw_ctrl", 32'(ctrl), 32'(CtrlLw));
    step();
    check_eq("lw_cnt", 32'(StallCnt), 32'd1);
    RdE = 5'd0;
    #2 check_eq("lw_x0_ctrl", 32'(ctrl), 32'(CtrlNone));
    step();
    check_eq("lw_x0_cnt", 32'(StallCnt), 32'd1);

    // Redirect together with load-use: redirect wins, both counters step.
    RdE = 5'd7; PCSrcE = 1'b1;
    #2 check_eq("redir_ctrl", 32'(ctrl), 32'(CtrlRedir));
    step();
    check_eq("redir_flushcnt", 32'(FlushCnt), 32'd1);
    check_eq("redir_stallcnt", 32'(StallCnt), 32'd2);
    PCSrcE = 1'b0; ResultSrcE0 = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
    CntClr = 1'b1;
    step();
    CntClr = 1'b0;
    check_eq("clr_both", 32'({StallCnt, FlushCnt}), 32'd0);

    // Single-cycle memory access causes no stall.
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #2 check_eq("mem_fast", 32'(ctrl), 32'(CtrlNone));
    step();

    // Three-cycle wait, redirect presented mid-wait must be held off.
    MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PCSrcE = (i == 1);
      #2 check_eq($sformatf("mem_wait%0d", i), 32'(ctrl), 32'(CtrlMem));
      step();
    end
    PCSrcE = 1'b0; MemReadyM = 1'b1;
    #2 check_eq("mem_release", 32'(ctrl), 32'(CtrlNone));
    step();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #2 check_eq("mem_idle", 32'(ctrl), 32'(CtrlNone));
    check_eq("mem_stallcnt", 32'(StallCnt), 32'd3);
    check_eq("mem_flushcnt", 32'(FlushCnt), 32'd0);
    check_eq("mem_noerr", 32'(MemErr), 32'd0);
    step();

    // Timeout: ERR after the 4th stalled cycle, sticky through MemReadyM.
    MemReqM = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("to_err%0d", i), 32'(MemErr), (i == 4) ? 32'd1 : 32'd0);
    end
    MemReadyM = 1'b1;
    step();
    step();
    check_eq("err_sticky", 32'(MemErr), 32'd1);
    check_eq("err_ctrl", 32'(ctrl), 32'(CtrlMem));
    check_eq("err_stallcnt", 32'(StallCnt), 32'd9);

    // Async reset away from any edge.
    #2 rst = 1'b0;
    #1;
    check_eq("arst_memerr", 32'(MemErr), 32'd0);
    check_eq("arst_cnts", 32'({StallCnt, FlushCnt}), 32'd0);
    check_eq("arst_ctrl", 32'(ctrl), 32'(CtrlNone));
    #2 rst = 1'b1;
    MemReqM = 1'b0; MemReadyM = 1'b0;
    step();

    // Saturation and clear-over-increment.
    ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
    for (int i = 0; i < 20; i++) step();
    check_eq("sat_stallcnt", 32'(StallCnt), 32'd15);
    CntClr = 1'b1;
    step();
    check_eq("clr_wins", 32'(StallCnt), 32'd0);
    CntClr = 1'b0;
    step();
    check_eq("post_clr_inc", 32'(StallCnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
